serial_divider: RTL and testbench
=================================

# serial_divider

Sequential shift-subtract (restoring) divider: a 2N-bit dividend divided by an N-bit divisor gives an N-bit quotient and an N-bit remainder, one quotient bit per clock. It is the inverse datapath of the team's serial shift-add multiplier and uses the same `start`/`ready` handshake, so the two blocks share one controller. Overflow and divide-by-zero are detected at load and reported without iterating.

## Interface
- `N`, default 8: divisor, quotient and remainder width. The dividend is 2N bits.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset: one clock, synchronous, active-low.
- `start`  input  1  load operands and begin a division. Sampled every edge.
- `Dividend`  input  2N  dividend; sampled only on a `start` edge.
- `Divisor`  input  N  divisor; sampled only on a `start` edge.
- `Quotient`  output  N  last completed quotient; registered.
- `Remainder`  output  N  last completed remainder; registered.
- `overflow`  output  1  the last operation overflowed or divided by zero; registered.
- `ready`  output  1  high when not busy and the results are valid.

## Operation
- States:
  - IDLE: `ready`=1.
  - BUSY: `ready`=0.
  - FIX: `ready`=0; exists only with `SERIAL_DIV_SIGNED_EN`.
- Internal registers:
  - 2N-bit work register W, loaded with `Dividend`; the upper half holds the partial remainder, the lower half the quotient bits.
  - N-bit divisor register D.
  - Counter of ceil(log2(N+1)) bits.
- `rst_n`=0 has priority over everything. Next state is IDLE; `Quotient`=0, `Remainder`=0, `overflow`=0, `ready`=1. W, D and the counter are cleared.
- `start`=1 in any state (including BUSY or FIX) aborts the current operation. It then loads W and D and clears the counter.
- Overflow check at the load edge: overflow when `Dividend[2N-1:N]` >= `Divisor`. This also covers `Divisor`=0.
  - On overflow, the state stays IDLE and `overflow`=1.
  - `Quotient` is set to all ones and `Remainder` to `Dividend[2N-1:N]`.
- Otherwise the state goes to BUSY and `overflow` is cleared.
- Each BUSY cycle performs one restoring step:
  - Form the (N+1)-bit value {W[2N-1:N], W[N-1]}.
  - Trial subtract D, computed N+1 bits wide so that no carry-out is lost.
  - If the result is non-negative: W = {diff[N-1:0], W[N-2:0], 1}.
  - Otherwise: W = {W shifted left by 1, 0}.
  - Increment the counter.
- Completion: on the N-th BUSY step the block registers `Quotient`=W[N-1:0] and `Remainder`=W[2N-1:N], computed from that step's result, and returns to IDLE.
- `Quotient`, `Remainder` and `overflow` change only at completion, at an overflow load, or at reset. They hold otherwise, including while BUSY.
- `start` held high restarts the operation every cycle, so `ready` stays low (or the overflow result is reloaded each cycle).

## Timing
- Normal load at edge k: `ready` falls after edge k and rises after edge k+N. Results are valid in the same cycle `ready` rises.
- Overflow load at edge k: `ready` stays 1 with no low pulse. `overflow` and the results update after edge k.
- With `SERIAL_DIV_SIGNED_EN`, FIX adds one cycle, so `ready` rises after edge k+N+1.
- Reset asserted mid-operation: the next edge gives the IDLE reset values. No partial result is ever published.
- `start` and `rst_n`=0 on the same edge: reset wins and the operands are discarded.

## Configuration
- `SERIAL_DIV_SIGNED_EN` undefined:
  - Operands and results are unsigned.
  - There is no FIX state; latency is N.
- `SERIAL_DIV_SIGNED_EN` defined:
  - Operands are two's complement.
  - The load stores magnitudes in W and D and records the signs.
  - Overflow check at load: |dividend upper half| >= |divisor|, or divisor zero.
  - FIX state rules:
    - The quotient is negated when the operand signs differ.
    - The remainder takes the dividend's sign (truncating division).
    - `overflow` is also set when the quotient magnitude exceeds 2^(N-1)-1 for a positive result or 2^(N-1) for a negative one.
  - On overflow, the results are set as for an unsigned overflow.

## Test plan
All scenarios use N=8.
1. Nominal: `Dividend`=0x03E8, `Divisor`=0x07, `start` for one cycle. Expect `Quotient`=0x8E, `Remainder`=0x06 and `overflow`=0, with `ready` low for exactly 8 cycles.
2. Overflow: 0x0800 / 0x08. Expect `overflow`=1, `Quotient`=0xFF and `Remainder`=0x08 after the load edge, with `ready` never falling.
3. Divide-by-zero: 0x0010 / 0x00. Expect `overflow`=1, `Quotient`=0xFF and `Remainder`=0x00.
4. Boundary: 0xFEFF / 0xFF. Expect `Quotient`=0xFF, `Remainder`=0xFE and `overflow`=0.
5. Abort and reset: start 0x03E8/0x07, then re-`start` with 0x0064/0x0A at BUSY step 4; expect `Quotient`=0x0A and `Remainder`=0x00 eight cycles after the second start. A separate run with `rst_n`=0 at step 4 gives `ready`=1 and all outputs 0.
6. Signed build: 0xFF9C / 0x07, i.e. -100/7. Expect `Quotient`=0xF2 (-14), `Remainder`=0xFE (-2) and `overflow`=0, with `ready` low for 9 cycles.

Source files
------------

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - restoring shift-subtract divider, 2N/N bits, one quotient bit per clock
// Optional two's-complement mode: define SERIAL_DIV_SIGNED_EN.
module serial_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] Dividend,
    input  logic [N-1:0]   Divisor,
    output logic [N-1:0]   Quotient,
    output logic [N-1:0]   Remainder,
    output logic           overflow,
    output logic           ready
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t         state, state_next;
    logic [2*N-1:0] w;
    logic [N-1:0]   d;
    logic [CW-1:0]  cnt;

    logic [2*N-1:0] ld_w;
    logic [N-1:0]   ld_d;
    logic           ld_ovf;
    logic [N:0]     rem_ext;
    logic [N+1:0]   diff;
    logic [2*N-1:0] w_step;
    logic           last;

`ifdef SERIAL_DIV_SIGNED_EN
    localparam logic [N-1:0] HALF = N'(1) << (N - 1);
    logic         q_neg, r_neg;
    logic [N-1:0] hi_raw;
    logic [N-1:0] q_mag, r_mag;
    logic         fix_ovf;

    // W and D always hold magnitudes; the signs are reapplied in FIX.
    assign ld_w = Dividend[2*N-1] ? -Dividend : Dividend;
    assign ld_d = Divisor[N-1] ? -Divisor : Divisor;
    assign q_mag = w[N-1:0];
    assign r_mag = w[2*N-1:N];
    assign fix_ovf = q_neg ? (q_mag > HALF) : (q_mag > HALF - N'(1));
`else
    assign ld_w = Dividend;
    assign ld_d = Divisor;
`endif

    // Also catches a zero divisor, since any upper half is >= 0.
    assign ld_ovf = ld_w[2*N-1:N] >= ld_d;

    // The (N+1)-bit partial remainder is widened once more so the borrow is the sign bit.
    assign rem_ext = {w[2*N-1:N], w[N-1]};
    assign diff    = {1'b0, rem_ext} - {2'b00, d};
    assign w_step  = diff[N+1] ? {w[2*N-2:0], 1'b0} : {diff[N-1:0], w[N-2:0], 1'b1};
    assign last    = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ld_ovf ? IDLE : BUSY;
        end else begin
            case (state)
`ifdef SERIAL_DIV_SIGNED_EN
                BUSY:    if (last) state_next = FIX;
`else
                BUSY:    if (last) state_next = IDLE;
`endif
                FIX:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ready = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w         <= '0;
            d         <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            overflow  <= 1'b0;
`ifdef SERIAL_DIV_SIGNED_EN
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            hi_raw    <= '0;
`endif
        end else if (start) begin
            w        <= ld_w;
            d        <= ld_d;
            cnt      <= '0;
            overflow <= ld_ovf;
            if (ld_ovf) begin
                Quotient  <= '1;
                Remainder <= Dividend[2*N-1:N];
            end
`ifdef SERIAL_DIV_SIGNED_EN
            q_neg  <= Dividend[2*N-1] ^ Divisor[N-1];
            r_neg  <= Dividend[2*N-1];
            hi_raw <= Dividend[2*N-1:N];
`endif
        end else if (state == BUSY) begin
            w   <= w_step;
            cnt <= cnt + 1'b1;
`ifndef SERIAL_DIV_SIGNED_EN
            if (last) begin
                Quotient  <= w_step[N-1:0];
                Remainder <= w_step[2*N-1:N];
                overflow  <= 1'b0;
            end
`endif
        end
`ifdef SERIAL_DIV_SIGNED_EN
        else if (state == FIX) begin
            if (fix_ovf) begin
                Quotient  <= '1;
                Remainder <= hi_raw;
                overflow  <= 1'b1;
            end else begin
                Quotient  <= q_neg ? -q_mag : q_mag;
                Remainder <= r_neg ? -r_mag : r_mag;
                overflow  <= 1'b0;
            end
        end
`endif
    end
endmodule

// File: tb/tb_serial_divider.sv
// tb/tb_serial_divider.sv - randomized self-checking bench for serial_divider (N=8)
`timescale 1ns/1ps
module tb_serial_divider;
    localparam int N = 8;
`ifdef SERIAL_DIV_SIGNED_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic [7:0]  quotient, remainder;
    logic        overflow, ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_divider #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .Dividend (dividend),
        .Divisor  (divisor),
        .Quotient (quotient),
        .Remainder(remainder),
        .overflow (overflow),
        .ready    (ready)
    );

    function automatic void ref_div(input logic [15:0] dd, input logic [7:0] dv,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic ovf, output int lat);
`ifdef SERIAL_DIV_SIGNED_EN
        int a, b, ma, mb, qi, ri;
        a  = int'($signed(dd));
        b  = int'($signed(dv));
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        if ((ma >> 8) >= mb) begin
            ovf = 1'b1; q = 8'hFF; r = dd[15:8]; lat = 0;
        end else begin
            qi  = a / b;
            ri  = a % b;
            lat = LAT;
            if (qi > 127 || qi < -128) begin
                ovf = 1'b1; q = 8'hFF; r = dd[15:8];
            end else begin
                ovf = 1'b0; q = qi[7:0]; r = ri[7:0];
            end
        end
`else
        logic [15:0] qq, rr;
        if (dd[15:8] >= dv) begin
            ovf = 1'b1; q = 8'hFF; r = dd[15:8]; lat = 0;
        end else begin
            qq  = dd / {8'h00, dv};
            rr  = dd % {8'h00, dv};
            ovf = 1'b0; q = qq[7:0]; r = rr[7:0]; lat = LAT;
        end
`endif
    endfunction

    // One start pulse; lat counts negedge samples with ready low, q_first is Quotient right after the load edge.
    task automatic do_op(input logic [15:0] dd, input logic [7:0] dv,
                         output int lat, output logic [7:0] q_first);
        @(negedge clk);
        start = 1'b1; dividend = dd; divisor = dv;
        @(negedge clk);
        start = 1'b0;
        q_first = quotient;
        lat = 0;
        while (ready !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; dividend = 16'h03E8; divisor = 8'h07;
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (quotient !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", quotient); end
        total++; if (remainder !== 8'h00) begin bad++; $display("FAIL reset_r got=%h want=00", remainder); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_discard_ready got=%b want=1", ready); end
    endtask

    task automatic test_directed(input string name, input logic [15:0] dd, input logic [7:0] dv,
                                 input logic [7:0] eq, input logic [7:0] er, input logic eo,
                                 input int elat);
        int lat;
        logic [7:0] q_before, q_first;
        q_before = quotient;
        do_op(dd, dv, lat, q_first);
        total++; if (lat !== elat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, elat); end
        total++; if (quotient !== eq) begin bad++; $display("FAIL %s_q got=%h want=%h", name, quotient, eq); end
        total++; if (remainder !== er) begin bad++; $display("FAIL %s_r got=%h want=%h", name, remainder, er); end
        total++; if (overflow !== eo) begin bad++; $display("FAIL %s_ovf got=%b want=%b", name, overflow, eo); end
        if (elat > 0) begin
            total++;
            if (q_first !== q_before) begin bad++; $display("FAIL %s_q_hold got=%h want=%h", name, q_first, q_before); end
        end
    endtask

    task automatic test_abort();
        int lat;
        logic [7:0] q_first;
        @(negedge clk);
        start = 1'b1; dividend = 16'h03E8; divisor = 8'h07;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        do_op(16'h0064, 8'h0A, lat, q_first);
        total++; if (lat !== LAT) begin bad++; $display("FAIL abort_latency got=%0d want=%0d", lat, LAT); end
        total++; if (quotient !== 8'h0A) begin bad++; $display("FAIL abort_q got=%h want=0a", quotient); end
        total++; if (remainder !== 8'h00) begin bad++; $display("FAIL abort_r got=%h want=00", remainder); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; dividend = 16'h03E8; divisor = 8'h07;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", ready); end
        total++; if (quotient !== 8'h00) begin bad++; $display("FAIL midreset_q got=%h want=00", quotient); end
        total++; if (remainder !== 8'h00) begin bad++; $display("FAIL midreset_r got=%h want=00", remainder); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midreset_ovf got=%b want=0", overflow); end
        repeat (12) @(negedge clk);
        total++; if (quotient !== 8'h00) begin bad++; $display("FAIL midreset_nopublish got=%h want=00", quotient); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] eq, er;
        logic eo;
        int elat;
        @(negedge clk);
        start = 1'b1; dividend = 16'hFF00; divisor = 8'h01;
        @(negedge clk);
        dividend = 16'h0050; divisor = 8'h03;
        @(negedge clk);
        dividend = 16'h1234; divisor = 8'h56;
        @(negedge clk);
        start = 1'b0;
        ref_div(16'h1234, 8'h56, eq, er, eo, elat);
        lat = 0;
        while (ready !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        total++; if (lat !== elat) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, elat); end
        total++; if (quotient !== eq) begin bad++; $display("FAIL b2b_q got=%h want=%h", quotient, eq); end
        total++; if (remainder !== er) begin bad++; $display("FAIL b2b_r got=%h want=%h", remainder, er); end
    endtask

    task automatic test_random(input int iters);
        int lat, elat;
        logic [15:0] dd;
        logic [7:0] dv, eq, er, q_first;
        logic eo;
        for (int i = 0; i < iters; i++) begin
            dv = 8'($urandom_range(0, 255));
            if (($urandom & 3) != 0 && dv != 8'h00)
                dd = {8'($urandom_range(0, int'(dv) - 1)), 8'($urandom)};
            else
                dd = 16'($urandom);
            ref_div(dd, dv, eq, er, eo, elat);
            do_op(dd, dv, lat, q_first);
            total++;
            if (lat !== elat || quotient !== eq || remainder !== er || overflow !== eo) begin
                bad++;
                $display("FAIL rand_%0d %h/%h got q=%h r=%h o=%b lat=%0d want q=%h r=%h o=%b lat=%0d",
                         i, dd, dv, quotient, remainder, overflow, lat, eq, er, eo, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed("nominal", 16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, LAT);
        test_directed("overflow", 16'h0800, 8'h08, 8'hFF, 8'h08, 1'b1, 0);
        test_directed("divzero", 16'h0010, 8'h00, 8'hFF, 8'h00, 1'b1, 0);
`ifdef SERIAL_DIV_SIGNED_EN
        test_directed("signed", 16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, LAT);
`else
        test_directed("boundary", 16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, LAT);
`endif
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random(80);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
